// File: rtl/mac_arb.sv
// Two-requester multiply-accumulate arbiter.
// A granted requester streams len operand pairs; the 8-bit sum of products is
// published on result and routed to port_A (below THRESH) or port_B.
module mac_arb #(
    parameter logic [7:0] THRESH = 8'd63
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [3:0] len0,
    input  logic [3:0] len1,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    input  logic [1:0] op_valid,
    output logic [1:0] gnt,
    output logic [1:0] op_ready,
    output logic       done,
    output logic       done_id,
    output logic [7:0] result,
    output logic [7:0] port_A,
    output logic [7:0] port_B
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e     state_q, state_d;
    logic       id_q, id_d;
    logic       ptr_q, ptr_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] acc_q, acc_d;
    logic [1:0] gnt_q, gnt_d;
    logic [7:0] result_q, result_d;
    logic [7:0] port_a_q, port_a_d;
    logic [7:0] port_b_q, port_b_d;

    logic       sel_id;
    logic [3:0] sel_len;
    logic [3:0] op_a, op_b;
    logic [7:0] prod;
    logic       hs;

    // Requester selection, owner operand mux and handshake decode
    always_comb begin
        // Both requesting: the round-robin pointer breaks the tie
        sel_id   = (req == 2'b11) ? ptr_q : req[1];
        sel_len  = sel_id ? len1 : len0;
        op_a     = id_q ? a1 : a0;
        op_b     = id_q ? b1 : b0;
        prod     = {4'd0, op_a} * {4'd0, op_b};
        op_ready = (state_q == StRun) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
        hs       = |(op_ready & op_valid);
    end

    // Next-state logic for the arbitration / accumulation FSM
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        gnt_d    = gnt_q;
        result_d = result_q;
        port_a_d = port_a_q;
        port_b_d = port_b_q;
        case (state_q)
            StIdle: begin
                if (|req) begin
                    id_d    = sel_id;
                    gnt_d   = sel_id ? 2'b10 : 2'b01;
                    acc_d   = 8'd0;
                    cnt_d   = sel_len;
                    state_d = (sel_len != 4'd0) ? StRun : StDone;
                end
            end
            StRun: begin
                // Abort wins over a same-cycle handshake
                if (!req[id_q]) begin
                    state_d = StIdle;
                    gnt_d   = 2'b00;
                    ptr_d   = ~id_q;
                end else if (hs) begin
                    acc_d = acc_q + prod;
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                result_d = acc_q;
                if (acc_q < THRESH) begin
                    port_a_d = acc_q;
                end else begin
                    port_b_d = acc_q;
                end
                gnt_d   = 2'b00;
                ptr_d   = ~id_q;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                gnt_d   = 2'b00;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            id_q     <= 1'b0;
            ptr_q    <= 1'b0;
            cnt_q    <= 4'd0;
            acc_q    <= 8'd0;
            gnt_q    <= 2'b00;
            result_q <= 8'd0;
            port_a_q <= 8'd0;
            port_b_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            gnt_q    <= gnt_d;
            result_q <= result_d;
            port_a_q <= port_a_d;
            port_b_q <= port_b_d;
        end
    end

    // Output drive
    always_comb begin
        gnt     = gnt_q;
        done    = (state_q == StDone);
        done_id = done & id_q;
        result  = result_q;
        port_A  = port_a_q;
        port_B  = port_b_q;
    end

endmodule

// File: tb/tb_mac_arb.sv
// Directed bench for mac_arb: single jobs, threshold routing, wrap, len=0,
// round-robin contention, abort and asynchronous reset mid-job.
module tb_mac_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [3:0] len0, len1, a0, b0, a1, b1;
    logic [1:0] op_valid;
    logic [1:0] gnt, op_ready;
    logic       done, done_id;
    logic [7:0] result, port_A, port_B;

    int n_checks = 0;
    int n_errors = 0;

    // Expected published values
    logic [7:0] exp_res, exp_pa, exp_pb;
    logic [3:0] va[8];
    logic [3:0] vb[8];

    mac_arb #(.THRESH(8'd63)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .len0     (len0),
        .len1     (len1),
        .a0       (a0),
        .b0       (b0),
        .a1       (a1),
        .b1       (b1),
        .op_valid (op_valid),
        .gnt      (gnt),
        .op_ready (op_ready),
        .done     (done),
        .done_id  (done_id),
        .result   (result),
        .port_A   (port_A),
        .port_B   (port_B)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Grant and ready must stay one-hot or zero at all times
    always @(negedge clk) begin
        chk("gnt_onehot0", {31'd0, $countones(gnt) <= 1}, 32'd1);
        chk("rdy_onehot0", {31'd0, $countones(op_ready) <= 1}, 32'd1);
    end

    task automatic do_reset();
        rst = 1'b0;
        req = 2'b00;
        op_valid = 2'b00;
        exp_res = 8'd0;
        exp_pa = 8'd0;
        exp_pb = 8'd0;
        #3;
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_result"}, {24'd0, result}, {24'd0, exp_res});
        chk({tag, "_portA"}, {24'd0, port_A}, {24'd0, exp_pa});
        chk({tag, "_portB"}, {24'd0, port_B}, {24'd0, exp_pb});
    endtask

    // Runs one job on requester id using va/vb, expecting exp_val
    task automatic run_job(input int id, input int len, input logic [7:0] exp_val,
                           input string tag);
        int k;
        int lat;
        int w;
        logic hs;
        k = 0;
        lat = 0;
        if (id == 0) len0 = len[3:0]; else len1 = len[3:0];
        req[id] = 1'b1;
        op_valid[id] = 1'b1;
        w = 0;
        while (!gnt[id] && w < 20) begin
            tick();
            w++;
        end
        chk({tag, "_gnt"}, {31'd0, gnt[id]}, 32'd1);
        while (!done && lat < 40) begin
            if (id == 0) begin
                a0 = va[k % 8]; b0 = vb[k % 8];
            end else begin
                a1 = va[k % 8]; b1 = vb[k % 8];
            end
            hs = op_ready[id] & op_valid[id];
            tick();
            if (hs) k++;
            lat++;
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_lat"}, lat, len);
        chk({tag, "_hs"}, k, len);
        chk({tag, "_done_id"}, {31'd0, done_id}, id);
        req[id] = 1'b0;
        op_valid[id] = 1'b0;
        tick();
        exp_res = exp_val;
        if (exp_val < 8'd63) exp_pa = exp_val; else exp_pb = exp_val;
        check_outputs(tag);
        chk({tag, "_gnt_clr"}, {30'd0, gnt}, 32'd0);
    endtask

    initial begin
        logic [1:0] g[3];
        logic [1:0] prev;
        int n;
        req = 2'b00; op_valid = 2'b00;
        len0 = 4'd0; len1 = 4'd0;
        a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0;
        rst = 1'b0;
        #2;
        chk("rst_gnt", {30'd0, gnt}, 32'd0);
        chk("rst_rdy", {30'd0, op_ready}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        do_reset();
        check_outputs("rst");

        // Contention: 0, 1, 0 from a fresh reset
        req = 2'b11; op_valid = 2'b11;
        len0 = 4'd1; len1 = 4'd1;
        a0 = 4'd1; b0 = 4'd2; a1 = 4'd3; b1 = 4'd3;
        prev = 2'b00;
        n = 0;
        for (int i = 0; i < 60 && n < 3; i++) begin
            tick();
            if (gnt != 2'b00 && prev == 2'b00) begin
                g[n] = gnt;
                n++;
            end
            prev = gnt;
        end
        chk("rr_count", n, 3);
        chk("rr_first", {30'd0, g[0]}, 32'd1);
        chk("rr_second", {30'd0, g[1]}, 32'd2);
        chk("rr_third", {30'd0, g[2]}, 32'd1);
        do_reset();

        // Single job; non-owner op_valid presented with big operands
        va[0] = 4'd2; vb[0] = 4'd3;
        va[1] = 4'd4; vb[1] = 4'd5;
        va[2] = 4'd1; vb[2] = 4'd1;
        a1 = 4'd15; b1 = 4'd15; op_valid[1] = 1'b1;
        run_job(0, 3, 8'd27, "single");
        a1 = 4'd0; b1 = 4'd0;
        tick();

        // Threshold routing to port_B
        va[0] = 4'd15; vb[0] = 4'd15;
        va[1] = 4'd3;  vb[1] = 4'd3;
        run_job(1, 2, 8'd234, "thresh");
        tick();

        // len = 0
        run_job(0, 0, 8'd0, "len0");
        tick();

        // Wrap modulo 256
        va[0] = 4'd15; vb[0] = 4'd15;
        va[1] = 4'd15; vb[1] = 4'd15;
        run_job(0, 2, 8'd194, "wrap");
        tick();

        // Abort after one handshake; requester 1 should win next
        len0 = 4'd3; len1 = 4'd3;
        a0 = 4'd2; b0 = 4'd3;
        req = 2'b01; op_valid = 2'b01;
        tick();
        chk("abort_gnt0", {30'd0, gnt}, 32'd1);
        tick();
        req = 2'b10; op_valid = 2'b00;
        tick();
        chk("abort_gnt_clr", {30'd0, gnt}, 32'd0);
        chk("abort_nodone", {31'd0, done}, 32'd0);
        tick();
        chk("abort_next_gnt", {30'd0, gnt}, 32'd2);
        check_outputs("abort");

        // Reset mid-RUN: outputs clear without waiting for a clock edge
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk("amid_gnt", {30'd0, gnt}, 32'd0);
        chk("amid_rdy", {30'd0, op_ready}, 32'd0);
        chk("amid_done", {31'd0, done}, 32'd0);
        chk("amid_result", {24'd0, result}, 32'd0);
        chk("amid_portA", {24'd0, port_A}, 32'd0);
        chk("amid_portB", {24'd0, port_B}, 32'd0);
        do_reset();

        // Fresh behaviour after reset
        va[0] = 4'd7; vb[0] = 4'd9;
        run_job(0, 1, 8'd63, "post_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
